// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode seven-segment driver with load-strobed value register.
// Optional leading-zero blanking is built when LEADING_ZERO_BLANK_EN is defined.
module hex_display_mux #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  enable,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VAL_W = 4 * DIGITS;
    localparam logic [6:0]  SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'b1000000;
            4'h1:    pat = 7'b1111001;
            4'h2:    pat = 7'b0100100;
            4'h3:    pat = 7'b0110000;
            4'h4:    pat = 7'b0011001;
            4'h5:    pat = 7'b0010010;
            4'h6:    pat = 7'b0000010;
            4'h7:    pat = 7'b1111000;
            4'h8:    pat = 7'b0000000;
            4'h9:    pat = 7'b0010000;
            4'hA:    pat = 7'b0001000;
            4'hB:    pat = 7'b0000011;
            4'hC:    pat = 7'b1000110;
            4'hD:    pat = 7'b0100001;
            4'hE:    pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    logic [VAL_W-1:0]  r_disp;
    logic [PRE_W-1:0]  r_pre;
    logic [IDX_W-1:0]  r_idx;
    logic [6:0]        r_seg;
    logic [DIGITS-1:0] r_an;

    logic [VAL_W-1:0]  w_disp_nxt;
    logic [PRE_W-1:0]  w_pre_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_pre_wrap;
    logic [3:0]        w_nib [DIGITS];
    logic [DIGITS-1:0] w_blank_lead;
    logic [6:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_an_nxt;
`ifdef LEADING_ZERO_BLANK_EN
    logic              w_upper_zero;
`endif

    // Next-state holding register, prescaler and digit index
    always_comb begin
        w_disp_nxt = load ? value : r_disp;
        w_pre_wrap = (r_pre == PRE_W'(SCAN_DIV - 1));
        w_pre_nxt  = w_pre_wrap ? '0 : r_pre + PRE_W'(1);
        w_idx_nxt  = r_idx;
        if (w_pre_wrap) begin
            w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_nib[i] = w_disp_nxt[4*i +: 4];
        end
    end

    // A digit is blanked when it and every more-significant nibble are zero; digit 0 never
    always_comb begin
        w_blank_lead = '0;
`ifdef LEADING_ZERO_BLANK_EN
        w_upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            w_upper_zero    = w_upper_zero & (w_nib[i] == 4'h0);
            w_blank_lead[i] = w_upper_zero;
        end
`endif
    end

    always_comb begin
        w_an_nxt            = '1;
        w_an_nxt[w_idx_nxt] = 1'b0;
        w_seg_nxt           = w_blank_lead[w_idx_nxt] ? SEG_BLANK : decode(w_nib[w_idx_nxt]);
        if (!enable) begin
            w_an_nxt  = '1;
            w_seg_nxt = SEG_BLANK;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_disp <= '0;
            r_pre  <= '0;
            r_idx  <= '0;
            r_seg  <= SEG_BLANK;
            r_an   <= '1;
        end else begin
            r_disp <= w_disp_nxt;
            r_pre  <= w_pre_nxt;
            r_idx  <= w_idx_nxt;
            r_seg  <= w_seg_nxt;
            r_an   <= w_an_nxt;
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule
